sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- SAP-1 controller-sequencer: a ring-counter T-state machine plus microcode decode.
- Generates every load, increment and bus-output-enable strobe for the 8-bit W bus.
- The *_OE outputs drive the G inputs of the quad tri-state bus-driver stages directly downstream. At most one driver may own the bus in any cycle.
- Opcode comes from the instruction register's upper nibble.

Parameters:
- OPW, 4, opcode width
- OP_LDA, 4'b0000, load A from RAM[addr]
- OP_ADD, 4'b0001, A <= A + RAM[addr]
- OP_SUB, 4'b0010, A <= A - RAM[addr]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, halt

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- CLR_N  input  1  asynchronous active-low reset
- RUN  input  1  1 = sequence advances; 0 = pause (state held, strobes suppressed)
- OPCODE  input  OPW  IR upper nibble; valid from T4 onward
- TSTATE  output  6  one-hot T1..T6 for the front-panel LEDs; 0 in RST and HALTED
- PC_INC  output  1  program counter count enable (Cp)
- PC_OE  output  1  PC drives bus (Ep)
- MAR_LD  output  1  MAR load (Lm)
- RAM_OE  output  1  RAM drives bus (CE)
- IR_LD  output  1  instruction register load (Li)
- IR_OE  output  1  IR address nibble drives bus (Ei)
- A_LD  output  1  accumulator load (La)
- A_OE  output  1  accumulator drives bus (Ea)
- B_LD  output  1  B register load (Lb)
- ALU_SUB  output  1  ALU subtract select (Su)
- ALU_OE  output  1  ALU drives bus (Eu)
- OUT_LD  output  1  output register load (Lo)
- HALT  output  1  clock-stop request to the clock module

Behaviour:
- Reset and output encoding:
  - States: RST, T1..T6, HALTED. State is registered; strobes are Moore/opcode-combinational decode of state.
  - CLR_N low, at any time including mid-instruction: state := RST immediately and asynchronously. All outputs are 0 while CLR_N is low and while in RST.
- RST: next edge with RUN=1 goes to T1; RUN=0 stays in RST.
- RUN gating:
  - Any T state with RUN=0: state holds and every strobe output is 0. TSTATE still shows the held state.
  - On resume, the held state's strobes assert for exactly one cycle. PC_INC is never issued twice for one T2.
- Transitions with RUN=1:
  - T1->T2->T3->T4->T5->T6->T1.
  - T4 with OPCODE==OP_HLT goes to HALTED.
- Fetch microcode (opcode independent):
  - T1: PC_OE, MAR_LD.
  - T2: PC_INC.
  - T3: RAM_OE, IR_LD.
- T4:
  - LDA/ADD/SUB: IR_OE, MAR_LD.
  - OUT: A_OE, OUT_LD.
  - HLT: HALT.
  - Other opcodes: no strobes (NOP).
- T5:
  - LDA: RAM_OE, A_LD.
  - ADD/SUB: RAM_OE, B_LD.
  - Others: none.
- T6:
  - ADD: ALU_OE, A_LD.
  - SUB: ALU_OE, ALU_SUB, A_LD.
  - Others: none.
- Every instruction takes 6 T states (no early termination), except HLT.
- HALTED: HALT=1, all other outputs 0, TSTATE=0. Ignores RUN and OPCODE; the only exit is CLR_N.
- Bus-ownership invariant: PC_OE+RAM_OE+IR_OE+A_OE+ALU_OE <= 1 in every cycle, all states, any OPCODE value.
- ALU_SUB is only ever high together with ALU_OE.
- OPCODE is ignored in RST, T1..T3 and HALTED. OPCODE X/Z in T1..T3 must not produce X on any output.
- Undefined opcodes behave as a 6-state NOP, with fetch strobes unchanged.

Test Plan:
- Reset/idle: CLR_N=0 for 3 cycles, release with RUN=0 for 4 cycles -> all outputs 0, TSTATE=0; RUN=1 -> next cycle TSTATE=000001, PC_OE=1, MAR_LD=1.
- LDA then ADD then SUB, RUN=1, OPCODE=0000/0001/0010 -> 18 cycles with T4..T6 strobes exactly as tabled. SUB T6 shows ALU_OE=1, ALU_SUB=1, A_LD=1. PC_INC high exactly 3 cycles total.
- OUT then HLT, OPCODE=1110 then 1111 -> OUT T4: A_OE=1, OUT_LD=1. HLT T4: HALT=1. Next cycle HALTED: HALT=1 held 20 cycles while RUN/OPCODE toggle. CLR_N pulse -> RST, HALT=0.
- Pause in T2: drop RUN for 5 cycles on entering T2 -> PC_INC=0 during pause, TSTATE=000010 held. Raise RUN -> PC_INC=1 for exactly one cycle, then T3.
- Async reset mid-instruction: assert CLR_N low between clock edges during T5 of LDA -> outputs 0 before the next CLK edge. After release and RUN=1, sequence restarts at T1.
- Contention sweep: randomized OPCODE 0..15 and RUN for 2000 cycles -> assertion that at most one *_OE is high never fires. Opcodes 0011..1101 produce no strobes in T4..T6.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// SAP-1 controller-sequencer: T-state ring sequencer plus microcode decode
// of every load, increment and bus-enable strobe for the 8-bit W bus.
module sap_control_sequencer #(
    parameter int             OPW    = 4,
    parameter logic [OPW-1:0] OP_LDA = 4'b0000,
    parameter logic [OPW-1:0] OP_ADD = 4'b0001,
    parameter logic [OPW-1:0] OP_SUB = 4'b0010,
    parameter logic [OPW-1:0] OP_OUT = 4'b1110,
    parameter logic [OPW-1:0] OP_HLT = 4'b1111
) (
    input  logic           clk_i,
    input  logic           clr_n_i,
    input  logic           run_i,
    input  logic [OPW-1:0] opcode_i,
    output logic [5:0]     tstate_o,
    output logic           pc_inc_o,
    output logic           pc_oe_o,
    output logic           mar_ld_o,
    output logic           ram_oe_o,
    output logic           ir_ld_o,
    output logic           ir_oe_o,
    output logic           a_ld_o,
    output logic           a_oe_o,
    output logic           b_ld_o,
    output logic           alu_sub_o,
    output logic           alu_oe_o,
    output logic           out_ld_o,
    output logic           halt_o
);

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_T6   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    logic [2:0] state_q, state_d;

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // HALTED is sticky: only the asynchronous clear leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  if (run_i) state_d = S_T1;
            S_T1:   if (run_i) state_d = S_T2;
            S_T2:   if (run_i) state_d = S_T3;
            S_T3:   if (run_i) state_d = S_T4;
            S_T4:   if (run_i) state_d = (opcode_i == OP_HLT) ? S_HALT : S_T5;
            S_T5:   if (run_i) state_d = S_T6;
            S_T6:   if (run_i) state_d = S_T1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        tstate_o  = 6'b000000;
        pc_inc_o  = 1'b0;
        pc_oe_o   = 1'b0;
        mar_ld_o  = 1'b0;
        ram_oe_o  = 1'b0;
        ir_ld_o   = 1'b0;
        ir_oe_o   = 1'b0;
        a_ld_o    = 1'b0;
        a_oe_o    = 1'b0;
        b_ld_o    = 1'b0;
        alu_sub_o = 1'b0;
        alu_oe_o  = 1'b0;
        out_ld_o  = 1'b0;
        halt_o    = 1'b0;

        if (state_q >= S_T1 && state_q <= S_T6)
            tstate_o = 6'b000001 << (state_q - S_T1);

        // Opcode is only consulted in T4..T6, so an unknown IR during fetch
        // cannot leak X onto the strobes.
        if (state_q == S_HALT) begin
            halt_o = 1'b1;
        end else if (run_i) begin
            case (state_q)
                S_T1: begin pc_oe_o = 1'b1; mar_ld_o = 1'b1; end
                S_T2: pc_inc_o = 1'b1;
                S_T3: begin ram_oe_o = 1'b1; ir_ld_o = 1'b1; end
                S_T4: begin
                    if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        ir_oe_o  = 1'b1;
                        mar_ld_o = 1'b1;
                    end else if (opcode_i == OP_OUT) begin
                        a_oe_o   = 1'b1;
                        out_ld_o = 1'b1;
                    end else if (opcode_i == OP_HLT) begin
                        halt_o   = 1'b1;
                    end
                end
                S_T5: begin
                    if (opcode_i == OP_LDA) begin
                        ram_oe_o = 1'b1;
                        a_ld_o   = 1'b1;
                    end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        ram_oe_o = 1'b1;
                        b_ld_o   = 1'b1;
                    end
                end
                S_T6: begin
                    if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        alu_oe_o  = 1'b1;
                        a_ld_o    = 1'b1;
                        alu_sub_o = (opcode_i == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed plus randomized checks of sap_control_sequencer against a
// step-count / microcode-table model of the SAP-1 instruction cycle.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       clr_n, run;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe, a_ld, a_oe, b_ld;
    logic alu_sub, alu_oe, out_ld, halt;

    int tests  = 0;
    int failed = 0;
    int mt     = 0;   // 0 = RST, 1..6 = T1..T6, 7 = HALTED
    int pcinc_seen;

    sap_control_sequencer dut (
        .clk_i(clk), .clr_n_i(clr_n), .run_i(run), .opcode_i(opcode),
        .tstate_o(tstate), .pc_inc_o(pc_inc), .pc_oe_o(pc_oe), .mar_ld_o(mar_ld),
        .ram_oe_o(ram_oe), .ir_ld_o(ir_ld), .ir_oe_o(ir_oe), .a_ld_o(a_ld),
        .a_oe_o(a_oe), .b_ld_o(b_ld), .alu_sub_o(alu_sub), .alu_oe_o(alu_oe),
        .out_ld_o(out_ld), .halt_o(halt)
    );

    always #5 clk = ~clk;

    // {tstate[5:0], pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe, a_ld, a_oe,
    //  b_ld, alu_sub, alu_oe, out_ld, halt}
    function automatic logic [18:0] observed();
        return {tstate, pc_inc, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe, a_ld, a_oe,
                b_ld, alu_sub, alu_oe, out_ld, halt};
    endfunction

    function automatic logic [18:0] expected(int t, logic r, logic [3:0] op);
        logic [12:0] s;
        logic [5:0]  ts;
        s  = '0;
        ts = (t >= 1 && t <= 6) ? (6'b1 << (t - 1)) : 6'b0;
        if (t == 7) s[0] = 1'b1;
        else if (t != 0 && r === 1'b1) begin
            if (t == 1) begin s[11] = 1; s[10] = 1; end
            if (t == 2) s[12] = 1;
            if (t == 3) begin s[9] = 1; s[8] = 1; end
            if (t == 4 && op <= 4'd2) begin s[7] = 1; s[10] = 1; end
            if (t == 4 && op === 4'd14) begin s[5] = 1; s[1] = 1; end
            if (t == 4 && op === 4'd15) s[0] = 1;
            if (t == 5 && op === 4'd0) begin s[9] = 1; s[6] = 1; end
            if (t == 5 && (op === 4'd1 || op === 4'd2)) begin s[9] = 1; s[4] = 1; end
            if (t == 6 && (op === 4'd1 || op === 4'd2)) begin s[2] = 1; s[6] = 1; end
            if (t == 6 && op === 4'd2) s[3] = 1;
        end
        return {ts, s};
    endfunction

    task automatic check(input string tag, input logic [18:0] exp);
        logic [18:0] obs;
        obs = observed();
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s mt=%0d observed=%b expected=%b", tag, mt, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input string tag, input logic r, input logic [3:0] op);
        run = r; opcode = op;
        #1 check(tag, expected(mt, r, op));
        if (pc_inc === 1'b1) pcinc_seen++;
        @(posedge clk);
        if (mt == 0) begin
            if (r) mt = 1;
        end else if (mt != 7 && r) begin
            if (mt == 4 && op === 4'd15) mt = 7;
            else mt = (mt == 6) ? 1 : mt + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        clr_n = 1'b0; mt = 0;
        for (int i = 0; i < n; i++) begin
            run = 1'($urandom_range(0, 1)); opcode = 4'($urandom_range(0, 15));
            #1 check("reset", 19'd0);
            @(negedge clk);
        end
        clr_n = 1'b1;
    endtask

    task automatic instr(input string tag, input logic [3:0] op);
        for (int i = 0; i < 6; i++) cycle(tag, 1'b1, op);
    endtask

    // Bus ownership and ALU_SUB qualification, checked every cycle.
    always @(negedge clk) begin
        #2;
        tests++;
        assert ((int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe)) <= 1
                && !(alu_sub && !alu_oe)) else begin
            failed++;
            $error("FAIL bus_invariant observed oe=%b%b%b%b%b sub=%b expected at most one oe",
                   pc_oe, ram_oe, ir_oe, a_oe, alu_oe, alu_sub);
        end
    end

    initial begin
        clr_n = 1'b0; run = 1'b0; opcode = 4'd0;
        @(negedge clk);
        do_reset(3);
        for (int i = 0; i < 4; i++) cycle("idle", 1'b0, 4'd0);
        cycle("start", 1'b1, 4'd0);

        // LDA/ADD/SUB with unknown opcode during fetch
        pcinc_seen = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) cycle("fetch_x", 1'b1, 4'bxxxx);
            for (int i = 0; i < 3; i++) cycle("alu_exec", 1'b1, 4'(k));
        end
        check_int("pc_inc_count", pcinc_seen, 3);

        instr("out", 4'd14);
        for (int i = 0; i < 4; i++) cycle("hlt", 1'b1, 4'd15);
        check_int("halted_state", mt, 7);
        for (int i = 0; i < 20; i++)
            cycle("halted", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        do_reset(1);
        check("after_clr", 19'd0);

        // pause in T2
        cycle("to_t1", 1'b1, 4'd0);
        cycle("t1", 1'b1, 4'd0);
        pcinc_seen = 0;
        for (int i = 0; i < 5; i++) cycle("pause_t2", 1'b0, 4'd0);
        cycle("resume_t2", 1'b1, 4'd0);
        check_int("pause_pc_inc", pcinc_seen, 1);
        cycle("t3", 1'b1, 4'd0);
        cycle("t4", 1'b1, 4'd0);

        // async clear between edges in LDA T5
        run = 1'b1; opcode = 4'd0;
        #1 check("t5_before_clr", expected(mt, 1'b1, 4'd0));
        #2 clr_n = 1'b0;
        #1 check("async_clr", 19'd0);
        mt = 0;
        @(negedge clk);
        clr_n = 1'b1;
        cycle("restart", 1'b1, 4'd0);
        cycle("restart_t1", 1'b1, 4'd0);

        for (int i = 0; i < 2000; i++) begin
            if (mt == 7 && $urandom_range(0, 3) == 0) do_reset(1);
            else cycle("random", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
